fir_ctrl: RTL and testbench
===========================

// Module: fir_ctrl
// PURPOSE
//  Sequencing controller for the FIR engine. Sits between the AXI-lite config block (ap_start, data_length),
//  the AXI-Stream ports, the tap/data BRAMs (bram11) and the MAC. Clears the data RAM, manages the
//  Tape_Num-deep circular sample buffer, issues tap/data read addresses, MAC strobes and output handshakes.
// PARAMETERS
//  pADDR_WIDTH  12  BRAM byte-address width
//  pDATA_WIDTH  32  sample/coefficient width
//  Tape_Num     11  number of taps = data RAM depth in words (max 16)
// PORTS
//  axis_clk     in   1   clock
//  axis_rst_n   in   1   asynchronous active-low reset
//  ap_start     in   1   start pulse from config block
//  data_length  in   32  number of samples/outputs this run
//  ap_done      out  1   run complete; sticky until next accepted ap_start
//  ap_idle      out  1   controller in IDLE
//  ss_tvalid    in   1   input stream valid
//  ss_tdata     in   32  input sample
//  ss_tlast     in   1   input last
//  ss_tready    out  1   input ready
//  sm_tready    in   1   output stream ready
//  sm_tvalid    out  1   output valid; data is MAC result, muxed at top level
//  sm_tlast     out  1   asserted with the data_length-th output
//  data_WE      out  4   data RAM byte write enables
//  data_EN      out  1   data RAM enable
//  data_A       out  12  data RAM byte address (4*index)
//  data_Di      out  32  data RAM write data
//  tap_EN       out  1   tap RAM enable (read only here)
//  tap_A        out  12  tap RAM byte address (4*k)
//  mac_clr      out  1   clear accumulator
//  mac_en       out  1   accumulate tap_Do*data_Do
//  err_tlast    out  1   sticky: ss_tlast disagreed with sample count
// BEHAVIOUR
//  Reset (async, any state): ap_idle=1; every other output 0; wp=0, counters=0; RAM contents untouched.
//  FSM: IDLE -> CLEAR -> WAIT_IN -> MAC -> OUT -> WAIT_IN ... -> DONE -> IDLE.
//  - IDLE: ap_start=1 clears ap_done and err_tlast and goes to CLEAR. ap_start in any other state is ignored.
//  - CLEAR: Tape_Num cycles. Write index 0..Tape_Num-1 with data_EN=1, data_WE=4'hF, data_Di=0. Then wp=0.
//    If data_length==0, go to DONE; otherwise go to WAIT_IN.
//  - WAIT_IN: ss_tready=1. On cycle T with ss_tvalid&ss_tready, write ss_tdata at data_A=4*wp (WE=4'hF)
//    and pulse mac_clr. data_Di=ss_tdata outside CLEAR.
//  - MAC: cycles T+1..T+Tape_Num issue k=0..Tape_Num-1: tap_A=4*k, data_A=4*((wp-k) mod Tape_Num),
//    with tap_EN=data_EN=1 and WE=0. BRAM read latency is 1 cycle, so mac_en=1 on T+2..T+Tape_Num+1.
//    Leave MAC after cycle T+Tape_Num+1.
//  - OUT: sm_tvalid=1 from T+Tape_Num+2 (T+13 at default) and held until sm_tready. ss_tready=0 throughout.
//    On the handshake: wp=(wp+1) mod Tape_Num; count+=1.
//    If count==data_length, sm_tlast is high in that beat and the FSM goes to DONE; otherwise WAIT_IN.
//  - DONE: one cycle, then ap_done=1, ap_idle=1, IDLE.
//  Count wraps only at data_length. It is 32-bit unsigned compared. The wp wrap is explicit modulo Tape_Num.
//  ss_tlast=1 on a sample other than number data_length, or 0 on the last one: set err_tlast and continue.
//    The run always ends on count.
//  RAM write (WAIT_IN, CLEAR) and reads (MAC) never share a cycle, so there is no collision.
// TESTING
//  1. Reset mid-MAC -> next edge: all outputs at reset values, ap_idle=1; restart completes normally.
//  2. data_length=3, ap_start -> 11 writes, data_A=0x00..0x28 with Di=0; then ss_tready=1.
//  3. Sample accepted at T -> mac_en T+2..T+12, sm_tvalid at T+13. Hold sm_tready=0 for 5 cycles:
//     tvalid stays high, ss_tready stays 0.
//  4. 13th sample (wp=1) -> data_A seq 0x04,0x00,0x28,0x24,...,0x08 against tap_A 0x00..0x28.
//  5. With bram11 x2 + MAC, coef {0,-10,-9,23,56,63,56,23,-9,-10,0}, 600 samples -> all match out_gold;
//     sm_tlast only on output 600; ap_done=1, ap_idle=1.
//  6. data_length=10, ss_tlast on sample 5 -> err_tlast=1, 10 outputs; data_length=0 -> ap_done after CLEAR.

Source files
------------

// File: rtl/fir_ctrl.sv
// Sequencing controller for the FIR engine: clears the data RAM, keeps a Tape_Num-deep
// circular sample buffer, issues tap/data reads and MAC strobes, and handshakes the streams.
module fir_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   ap_start,
    input  logic [31:0]            data_length,
    output logic                   ap_done,
    output logic                   ap_idle,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic                   sm_tlast,
    output logic [3:0]             data_WE,
    output logic                   data_EN,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic [pDATA_WIDTH-1:0] data_Di,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic                   mac_clr,
    output logic                   mac_en,
    output logic                   err_tlast
);
    localparam int IW = 4;
    localparam int KW = 5;
    localparam logic [KW-1:0] LP_TAPS   = KW'(Tape_Num);
    localparam logic [KW-1:0] LP_KLAST  = KW'(Tape_Num - 1);
    localparam logic [IW-1:0] LP_TAPS_I = IW'(Tape_Num);
    localparam logic [IW-1:0] LP_WPLAST = IW'(Tape_Num - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_OUT, S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [KW-1:0] r_k;
    logic [IW-1:0] r_wp;
    logic [31:0]   r_count;
    logic [31:0]   r_len;
    logic          r_done;
    logic          r_err;

    logic          w_lastOut;
    logic          w_clearEnd;
    logic [IW-1:0] w_kIdx;
    logic [IW-1:0] w_rdIdx;
    logic [IW-1:0] w_wpNext;
    logic [31:0]   w_countNext;

    function automatic logic [pADDR_WIDTH-1:0] f_byteAddr(input logic [IW-1:0] idx);
        return pADDR_WIDTH'({idx, 2'b00});
    endfunction

    assign w_countNext = r_count + 32'd1;
    assign w_lastOut   = (w_countNext == r_len);
    assign w_clearEnd  = (r_k == LP_KLAST);
    assign w_kIdx      = r_k[IW-1:0];
    // Newest sample sits at wp; tap k pairs with the sample k positions older.
    assign w_rdIdx     = (r_wp >= w_kIdx) ? (r_wp - w_kIdx) : (r_wp + LP_TAPS_I - w_kIdx);
    assign w_wpNext    = (r_wp == LP_WPLAST) ? '0 : (r_wp + IW'(1));

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (ap_start) w_next = S_CLEAR;
            S_CLEAR:   if (w_clearEnd) w_next = (r_len == 32'd0) ? S_DONE : S_WAIT_IN;
            S_WAIT_IN: if (ss_tvalid) w_next = S_MAC;
            S_MAC:     if (r_k == LP_TAPS) w_next = S_OUT;
            S_OUT:     if (sm_tready) w_next = w_lastOut ? S_DONE : S_WAIT_IN;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // r_k counts clear writes in CLEAR and tap issues plus one drain cycle in MAC.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_k     <= '0;
            r_wp    <= '0;
            r_count <= '0;
            r_len   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_k     <= '0;
                        r_wp    <= '0;
                        r_count <= '0;
                        r_len   <= data_length;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_k <= w_clearEnd ? '0 : (r_k + KW'(1));
                    if (w_clearEnd) r_wp <= '0;
                end
                S_WAIT_IN: begin
                    if (ss_tvalid) begin
                        r_k <= '0;
                        if (ss_tlast != w_lastOut) r_err <= 1'b1;
                    end
                end
                S_MAC: r_k <= r_k + KW'(1);
                S_OUT: begin
                    if (sm_tready) begin
                        r_wp    <= w_wpNext;
                        r_count <= w_countNext;
                    end
                end
                S_DONE:  r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        ap_idle   = 1'b0;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        sm_tlast  = 1'b0;
        data_WE   = 4'h0;
        data_EN   = 1'b0;
        data_A    = '0;
        data_Di   = '0;
        tap_EN    = 1'b0;
        tap_A     = '0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        case (r_state)
            S_IDLE: ap_idle = 1'b1;
            S_CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = f_byteAddr(w_kIdx);
            end
            S_WAIT_IN: begin
                ss_tready = 1'b1;
                data_Di   = ss_tdata;
                if (ss_tvalid) begin
                    data_EN = 1'b1;
                    data_WE = 4'hF;
                    data_A  = f_byteAddr(r_wp);
                    mac_clr = 1'b1;
                end
            end
            S_MAC: begin
                // Read data returns one cycle after issue, so accumulation lags by one.
                mac_en = (r_k != '0);
                if (r_k != LP_TAPS) begin
                    data_EN = 1'b1;
                    tap_EN  = 1'b1;
                    data_A  = f_byteAddr(w_rdIdx);
                    tap_A   = f_byteAddr(w_kIdx);
                end
            end
            S_OUT: begin
                sm_tvalid = 1'b1;
                sm_tlast  = w_lastOut;
            end
            default: ;
        endcase
    end

    assign ap_done   = r_done;
    assign err_tlast = r_err;

endmodule

// File: tb/tb_fir_ctrl.sv
// Bench for fir_ctrl: behavioural tap/data RAMs and MAC around the controller, with outputs
// checked against a direct convolution of the random samples.
module tb_fir_ctrl;
    localparam int N = 11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ap_start;
    logic [31:0] data_length;
    logic        ap_done, ap_idle;
    logic        ss_tvalid, ss_tlast, ss_tready;
    logic [31:0] ss_tdata;
    logic        sm_tready, sm_tvalid, sm_tlast;
    logic [3:0]  data_WE;
    logic        data_EN, tap_EN, mac_clr, mac_en, err_tlast;
    logic [11:0] data_A, tap_A;
    logic [31:0] data_Di;

    logic [31:0] dram [0:15];
    logic [31:0] tram [0:15];
    logic [31:0] data_Do, tap_Do, acc;
    bit          seeded;

    int nChecks = 0;
    int nFail   = 0;
    int h [N] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    int xq [$];

    always #5 clk = ~clk;

    fir_ctrl dut (
        .axis_clk(clk), .axis_rst_n(rst_n), .ap_start(ap_start), .data_length(data_length),
        .ap_done(ap_done), .ap_idle(ap_idle), .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata),
        .ss_tlast(ss_tlast), .ss_tready(ss_tready), .sm_tready(sm_tready), .sm_tvalid(sm_tvalid),
        .sm_tlast(sm_tlast), .data_WE(data_WE), .data_EN(data_EN), .data_A(data_A),
        .data_Di(data_Di), .tap_EN(tap_EN), .tap_A(tap_A), .mac_clr(mac_clr), .mac_en(mac_en),
        .err_tlast(err_tlast)
    );

    // Data RAM starts with nonzero junk so the clear pass matters.
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 16; i++) dram[i] <= 32'hDEAD_0000 + 32'(i);
            seeded <= 1'b1;
        end else if (data_EN) begin
            data_Do <= dram[data_A[5:2]];
            if (data_WE == 4'hF) dram[data_A[5:2]] <= data_Di;
        end
    end

    always @(posedge clk) begin
        if (tap_EN) tap_Do <= tram[tap_A[5:2]];
        if (mac_clr) acc <= 32'd0;
        else if (mac_en) acc <= acc + tap_Do * data_Do;
    end

    initial begin
        for (int i = 0; i < 16; i++) tram[i] = (i < N) ? 32'(h[i]) : 32'd0;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int goldY(int n);
        int s = 0;
        for (int k = 0; k < N; k++) if (n - k >= 0) s += h[k] * xq[n - k];
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_idle"}, 32'(ap_idle), 32'd1);
        checkOutput({tag, "_done"}, 32'(ap_done), 32'd0);
        checkOutput({tag, "_err"}, 32'(err_tlast), 32'd0);
        checkOutput({tag, "_ready"}, 32'({ss_tready, sm_tvalid, sm_tlast}), 32'd0);
        checkOutput({tag, "_ram"}, 32'({data_WE, data_EN, tap_EN}), 32'd0);
        checkOutput({tag, "_addr"}, 32'({data_A, tap_A}), 32'd0);
        checkOutput({tag, "_di"}, data_Di, 32'd0);
        checkOutput({tag, "_mac"}, 32'({mac_clr, mac_en}), 32'd0);
    endtask

    // One complete run: start, clear, len samples with full cycle-level checks, then done.
    task automatic applyStimulus(input int len, input int tlastAt, input bit detail, input bit stall);
        xq.delete();
        @(negedge clk);
        ap_start = 1'b1;
        data_length = 32'(len);
        @(negedge clk);
        ap_start = 1'b0;
        checkOutput("start_done_cleared", 32'(ap_done), 32'd0);
        checkOutput("start_err_cleared", 32'(err_tlast), 32'd0);
        for (int i = 0; i < N; i++) begin
            if (detail) begin
                checkOutput("clr_en_we", 32'({data_EN, data_WE}), 32'h1F);
                checkOutput("clr_addr", 32'(data_A), 32'(4 * i));
                checkOutput("clr_di", data_Di, 32'd0);
                checkOutput("clr_ss_tready", 32'(ss_tready), 32'd0);
            end
            @(negedge clk);
        end
        for (int n = 0; n < len; n++) begin
            xq.push_back(int'($urandom_range(0, 4095)) - 2048);
            checkOutput("ss_tready", 32'(ss_tready), 32'd1);
            ss_tvalid = 1'b1;
            ss_tdata  = 32'(xq[n]);
            ss_tlast  = (n + 1 == tlastAt);
            #1;
            checkOutput("wr_clr", 32'(mac_clr), 32'd1);
            checkOutput("wr_we", 32'(data_WE), 32'hF);
            checkOutput("wr_addr", 32'(data_A), 32'(4 * (n % N)));
            checkOutput("wr_di", data_Di, 32'(xq[n]));
            @(negedge clk);
            ss_tvalid = 1'b0;
            ss_tlast  = 1'b0;
            for (int c = 1; c <= N + 1; c++) begin
                checkOutput("mac_en", 32'(mac_en), 32'(c >= 2));
                if (detail && c <= N) begin
                    checkOutput("rd_tap_A", 32'(tap_A), 32'(4 * (c - 1)));
                    checkOutput("rd_data_A", 32'(data_A), 32'(4 * (((n % N) - (c - 1) + N) % N)));
                    checkOutput("rd_en_we", 32'({tap_EN, data_EN, data_WE}), 32'h30);
                end
                @(negedge clk);
            end
            if (stall && n == 0) begin
                repeat (5) begin
                    checkOutput("stall_tvalid", 32'(sm_tvalid), 32'd1);
                    checkOutput("stall_ss_tready", 32'(ss_tready), 32'd0);
                    @(negedge clk);
                end
            end
            checkOutput("sm_tvalid", 32'(sm_tvalid), 32'd1);
            checkOutput("sm_tdata", acc, 32'(goldY(n)));
            checkOutput("sm_tlast", 32'(sm_tlast), 32'(n + 1 == len));
            sm_tready = 1'b1;
            @(negedge clk);
            sm_tready = 1'b0;
        end
        checkOutput("done_state_done", 32'(ap_done), 32'd0);
        checkOutput("done_state_idle", 32'(ap_idle), 32'd0);
        @(negedge clk);
        checkOutput("end_done", 32'(ap_done), 32'd1);
        checkOutput("end_idle", 32'(ap_idle), 32'd1);
        checkOutput("end_err_tlast", 32'(err_tlast), 32'(len > 0 && tlastAt != len));
    endtask

    initial begin
        rst_n = 1'b0;
        ap_start = 1'b0;
        data_length = 32'd0;
        ss_tvalid = 1'b0;
        ss_tdata = 32'd0;
        ss_tlast = 1'b0;
        sm_tready = 1'b0;
        @(negedge clk);
        checkReset("por");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] short run with clear and stall checks");
        applyStimulus(3, 3, 1'b1, 1'b1);
        $display("[TB] run wrapping the circular buffer");
        applyStimulus(14, 14, 1'b1, 1'b0);

        $display("[TB] reset in the middle of a MAC pass");
        @(negedge clk);
        ap_start = 1'b1;
        data_length = 32'd5;
        @(negedge clk);
        ap_start = 1'b0;
        repeat (N) @(negedge clk);
        ss_tvalid = 1'b1;
        ss_tdata = 32'd7;
        @(negedge clk);
        ss_tvalid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("pre_reset_mac_en", 32'(mac_en), 32'd1);
        rst_n = 1'b0;
        #1;
        checkReset("async_rst");
        @(negedge clk);
        checkReset("held_rst");
        rst_n = 1'b1;
        applyStimulus(4, 4, 1'b0, 1'b0);

        $display("[TB] long run");
        applyStimulus(600, 600, 1'b0, 1'b0);
        $display("[TB] misplaced tlast");
        applyStimulus(10, 5, 1'b0, 1'b0);
        $display("[TB] zero-length run");
        applyStimulus(0, 0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
